// File: rtl/axi_read_vector_if.sv
// AXI-Stream interface used between the vector writer and axi_read_vector.
// Carries tvalid/tready/tdata/tlast only; the bus is clocked by its endpoints.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_read_vector.sv
// axi_read_vector: AXI-Stream to parallel vector deserializer.
// Collects ceil(vec_length/AXI_DATA_WIDTH) beats into a padded buffer, beat k
// at bits [k*W +: W], and presents the top MAX_VEC_LENGTH bits as vec.
// Optional feature macro: AXI_READ_VECTOR_TLAST_CHECK_EN adds the sticky
// tlast_err port flagging tlast on any beat that is not the vector's last.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The stream side accepts beats only in COLLECT (tready is a
// decode of the registered state); the vector side holds vec_valid and a
// stable vec in HOLD until vec_ready is seen.
module axi_read_vector #(
    parameter int MAX_VEC_LENGTH   = 10,
    parameter int AXI_DATA_WIDTH   = 4,
    parameter int MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
    axi_stream_if.slave                 data_in,
    output logic [MAX_VEC_LENGTH-1:0]   vec,
    output logic                        vec_valid,
    input  logic                        vec_ready,
    output logic                        last_read
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
    ,
    output logic                        tlast_err
`endif
);

    localparam int MAX_CHUNKS = (MAX_VEC_LENGTH + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
    localparam int PAD        = MAX_CHUNKS * AXI_DATA_WIDTH;
    localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PAD-1:0]   buf_q;
    logic [CNT_W-1:0] chunk_cnt;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] total_chunks;
    logic             start_accept;
    logic             beat_fire;
    logic             last_beat;

    // Beat count for the requested length; lengths whose count does not fit
    // the chunk counter wrap, exactly as a plain truncation would.
    assign total_chunks = CNT_W'((32'(vec_length) + 32'(AXI_DATA_WIDTH) - 32'd1)
                                / 32'(AXI_DATA_WIDTH));

    assign start_accept = (state == IDLE) && start && (total_chunks != '0);
    assign beat_fire    = (state == COLLECT) && data_in.tvalid;
    assign last_beat    = (chunk_cnt == total_q - CNT_ONE);

    assign data_in.tready = (state == COLLECT);
    assign vec_valid      = (state == HOLD);
    assign vec            = buf_q[PAD-1 -: MAX_VEC_LENGTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: start only matters in IDLE, beats only in COLLECT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_accept) state_next = COLLECT;
            COLLECT: if (beat_fire && last_beat) state_next = HOLD;
            HOLD:    if (vec_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Buffer, chunk counter and last_read: cleared on an accepted start,
    // filled one chunk per accepted beat, untouched by the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            chunk_cnt <= '0;
            total_q   <= '0;
            last_read <= 1'b0;
        end else if (start_accept) begin
            buf_q     <= '0;
            chunk_cnt <= '0;
            total_q   <= total_chunks;
            last_read <= 1'b0;
        end else if (beat_fire) begin
            for (int k = 0; k < MAX_CHUNKS; k++) begin
                if (chunk_cnt == CNT_W'(k)) begin
                    buf_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= data_in.tdata;
                end
            end
            chunk_cnt <= chunk_cnt + CNT_ONE;
            if (last_beat) begin
                last_read <= data_in.tlast;
            end
        end
    end

`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
    // Sticky framing error: tlast seen on a beat that is not the final one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlast_err <= 1'b0;
        end else if (beat_fire && data_in.tlast && !last_beat) begin
            tlast_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_read_vector.sv
// Directed bench for axi_read_vector with MAX_VEC_LENGTH=10, AXI_DATA_WIDTH=4.
// Table of vectors plus hand sequences for zero length, stalls, held-off
// vec_ready, mid-vector reset and (with the macro) misplaced tlast.
module tb_axi_read_vector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] vec_length;
    logic [9:0] vec;
    logic       vec_valid;
    logic       vec_ready;
    logic       last_read;
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
    logic       tlast_err;
`endif

    axi_stream_if #(.DATA_WIDTH(4)) s_if ();

    axi_read_vector #(
        .MAX_VEC_LENGTH(10),
        .AXI_DATA_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_length(vec_length),
        .data_in   (s_if),
        .vec       (vec),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .last_read (last_read)
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
        ,
        .tlast_err (tlast_err)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];

    typedef struct packed {
        logic [3:0]  len;
        logic [1:0]  nbeats;
        logic [11:0] beats;
        logic [2:0]  lasts;
        logic [9:0]  exp_vec;
        logic        exp_last;
    } vec_rec_t;

    vec_rec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [3:0] len);
        start      = 1'b1;
        vec_length = len;
        @(negedge clk);
        start      = 1'b0;
        vec_length = 4'hx;
    endtask

    // Offers one beat and waits (bounded) for it to be taken.
    task automatic send_beat(input logic [3:0] d, input logic l);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        while (!s_if.tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: tready got 0, expected 1 within 50 cycles");
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Scoreboard: compare presented vector with the oldest expectation.
    task automatic sb_check(input string name, input logic exp_last);
        logic [9:0] e;
        chk({name, "_vec_valid"}, vec_valid, 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: got empty queue, expected an entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_vec"}, vec, e);
        end
        chk({name, "_last_read"}, last_read, exp_last);
    endtask

    task automatic release_vector(input logic [9:0] exp_vec);
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        chk("valid_drop", vec_valid, 0);
        chk("vec_kept", vec, exp_vec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        //           len    nb    beats(b2,b1,b0)  lasts   vec     last
        tbl[0] = '{4'd10, 2'd3, 12'hA34,          3'b100, 10'h28D, 1'b1};
        tbl[1] = '{4'd3,  2'd1, 12'h00C,          3'b000, 10'h003, 1'b0};
        tbl[2] = '{4'd4,  2'd1, 12'h00F,          3'b001, 10'h003, 1'b1};
        tbl[3] = '{4'd5,  2'd2, 12'h095,          3'b010, 10'h025, 1'b1};
        tbl[4] = '{4'd8,  2'd2, 12'h0FF,          3'b010, 10'h03F, 1'b1};
        tbl[5] = '{4'd9,  2'd3, 12'h821,          3'b000, 10'h208, 1'b0};

        rst_n       = 1'b0;
        start       = 1'b0;
        vec_length  = 4'd0;
        vec_ready   = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 4'h0;
        s_if.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", vec, 0);
        chk("rst_vec_valid", vec_valid, 0);
        chk("rst_tready", s_if.tready, 0);
        chk("rst_last_read", last_read, 0);
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
        chk("rst_tlast_err", tlast_err, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors, beats back to back.
        for (int i = 0; i < 6; i++) begin
            chk("idle_tready", s_if.tready, 0);
            do_start(tbl[i].len);
            chk("tready_after_start", s_if.tready, 1);
            exp_q.push_back(tbl[i].exp_vec);
            for (int j = 0; j < int'(tbl[i].nbeats); j++) begin
                send_beat(tbl[i].beats[j*4 +: 4], tbl[i].lasts[j]);
                if (j < int'(tbl[i].nbeats) - 1) begin
                    chk("mid_vec_valid", vec_valid, 0);
                    chk("mid_tready", s_if.tready, 1);
                end
            end
            sb_check("table", tbl[i].exp_last);
            chk("hold_tready", s_if.tready, 0);
            release_vector(tbl[i].exp_vec);
        end

        // Zero length: nothing starts, previous vector is left in place.
        do_start(4'd0);
        for (int c = 0; c < 3; c++) begin
            chk("zero_tready", s_if.tready, 0);
            chk("zero_vec_valid", vec_valid, 0);
            @(negedge clk);
        end
        chk("zero_vec_kept", vec, 10'h208);

        // Gapped beats and vec_ready held low for 5 cycles.
        do_start(4'd10);
        exp_q.push_back(10'h28D);
        send_beat(4'h4, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("gap_tready", s_if.tready, 1);
            chk("gap_vec_valid", vec_valid, 0);
        end
        send_beat(4'h3, 1'b0);
        repeat (2) @(negedge clk);
        send_beat(4'hA, 1'b1);
        sb_check("gap", 1'b1);
        for (int c = 0; c < 5; c++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 4'hF;
            chk("hold_valid", vec_valid, 1);
            chk("hold_no_tready", s_if.tready, 0);
            chk("hold_vec_stable", vec, 10'h28D);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        release_vector(10'h28D);

        // Asynchronous reset after 2 of 3 beats.
        do_start(4'd10);
        send_beat(4'h4, 1'b0);
        send_beat(4'h3, 1'b0);
        chk("partial_vec", vec, 10'h00D);
        rst_n = 1'b0;
        #1;
        chk("arst_vec", vec, 0);
        chk("arst_vec_valid", vec_valid, 0);
        chk("arst_tready", s_if.tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(4'd10);
        exp_q.push_back(10'h28D);
        send_beat(4'h4, 1'b0);
        send_beat(4'h3, 1'b0);
        send_beat(4'hA, 1'b1);
        sb_check("after_rst", 1'b1);
        release_vector(10'h28D);

        // tlast on a middle beat: vector still completes.
        do_start(4'd10);
        exp_q.push_back(10'h28D);
        send_beat(4'h4, 1'b0);
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
        chk("err_before", tlast_err, 0);
`endif
        send_beat(4'h3, 1'b1);
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
        chk("err_set", tlast_err, 1);
`endif
        chk("early_tlast_tready", s_if.tready, 1);
        send_beat(4'hA, 1'b1);
        sb_check("early_tlast", 1'b1);
        release_vector(10'h28D);
`ifdef AXI_READ_VECTOR_TLAST_CHECK_EN
        repeat (2) @(negedge clk);
        chk("err_sticky", tlast_err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_vector.md
# axi_read_vector

Stream-to-vector deserializer for the puzzle datapath. It collects AXI-Stream beats and reassembles them into one parallel bit vector of a run-time length. It then presents the vector to the downstream compute stage with a valid/ready handshake. It sits directly downstream of the vector writer and uses the same chunk packing, so a vector written by one block is recovered bit-exactly by the other.

## Interface
- MAX_VEC_LENGTH, no default: maximum vector length in bits, ≥1.
- AXI_DATA_WIDTH, no default: stream tdata width in bits.
- MAX_VEC_LENGTH_W, default `MAX_VEC_LENGTH<=1 ? 1 : $clog2(MAX_VEC_LENGTH+1)`: width of vec_length.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to receive one vector; sampled only in IDLE.
- vec_length  in  MAX_VEC_LENGTH_W  length in bits of the vector to receive; sampled with start.
- data_in  axi_stream_if.slave  tdata AXI_DATA_WIDTH; uses tvalid, tready, tdata, tlast.
- vec  out  MAX_VEC_LENGTH  assembled vector; stable while vec_valid=1.
- vec_valid  out  1  vector available.
- vec_ready  in  1  downstream accepts vec.
- last_read  out  1  tlast value captured on the final beat of the vector.
- tlast_err  out  1  sticky framing error; present only with AXI_READ_VECTOR_TLAST_CHECK_EN.

## Operation
- Derived sizes:
  - MAX_CHUNKS = ceil(MAX_VEC_LENGTH/AXI_DATA_WIDTH).
  - PAD = MAX_CHUNKS*AXI_DATA_WIDTH.
  - total_chunks = ceil(vec_length/AXI_DATA_WIDTH), computed at 32 bits and then truncated to the chunk counter width.
- Packing:
  - Internal buffer buf[PAD-1:0].
  - Beat k is written to buf[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
  - vec = buf[PAD-1 -: MAX_VEC_LENGTH]. The low PAD-MAX_VEC_LENGTH bits are padding and are discarded.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE, start=1, total_chunks≠0: latch total_chunks, clear buf and chunk counter, go to COLLECT.
  - IDLE, start=1, total_chunks=0: stay in IDLE. Nothing happens.
  - COLLECT: on each tvalid&&tready, write the beat and increment the counter. On the beat where counter==total_chunks-1, capture tlast into last_read and go to HOLD.
  - HOLD: vec_valid=1. When vec_ready=1, go to IDLE.
- data_in.tready = (state==COLLECT), as a registered-state decode. No beats are accepted in IDLE or HOLD.
- start asserted in COLLECT or HOLD is ignored; it is not queued.
- vec_length changes after start are ignored until the next accepted start.
- Buffer bits beyond total_chunks beats remain zero from the clear at start.

## Timing
- Reset values: state IDLE, buf 0, counter 0. Outputs: vec 0, vec_valid 0, tready 0, last_read 0, tlast_err 0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous reset), and any partial vector is discarded.
- tready rises one cycle after the accepted start.
- Throughput: 1 beat/cycle while the upstream holds tvalid.
- vec_valid rises the cycle after the final handshake.
- Latency: minimum start→vec_valid is total_chunks+1 cycles.
- vec_valid drops the cycle after vec_valid&&vec_ready.
- A new start is accepted no earlier than the cycle after the handshake, since the block is then in IDLE.
- vec and last_read hold their values until the next accepted start clears them; vec is not cleared on the handshake.
- A tvalid stall mid-vector holds the counter. There is no timeout.

## Configuration
- AXI_READ_VECTOR_TLAST_CHECK_EN defined:
  - tlast_err is a port.
  - It is set on any beat accepted with tlast=1 that is not the final beat of its vector.
  - It is sticky until reset.
  - The beat is still stored and collection continues.
- Undefined:
  - The tlast_err port and its logic are absent.
  - tlast is used only to capture last_read.

## Test plan
Use MAX_VEC_LENGTH=10, AXI_DATA_WIDTH=4 (MAX_CHUNKS=3, PAD=12) throughout.
- start with vec_length=10; beats 0x4, 0x3, 0xA (tlast on the last) -> vec=0x28D, last_read=1, vec_valid one cycle after the third beat.
- start with vec_length=3; one beat 0xC, tlast=0 -> vec=0x003, last_read=0, tready low after 1 beat.
- start with vec_length=0 -> stays IDLE, tready never rises, vec_valid stays 0.
- vec_length=10 with tvalid gapped 2 cycles between beats and vec_ready held low 5 cycles -> same vec=0x28D; vec_valid held 5 cycles; beats offered in HOLD are not accepted (tready=0).
- rst_n pulsed low after 2 of 3 beats -> immediately vec_valid=0, tready=0, vec=0; a subsequent full transfer yields the correct vector.
- With CHECK_EN: vec_length=10, tlast=1 on beat 2 of 3 -> tlast_err=1 and stays 1; the vector still completes after beat 3.
